// File: rtl/ok_axi4lite_reg_slave.sv
// AXI4-Lite register slave: NUM_REGS read/write control words followed by
// NUM_REGS read-only status words, with a per-register write strobe.
module ok_axi4lite_reg_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_REGS   = 8
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [32*NUM_REGS-1:0]  ctrl_out,
    input  logic [32*NUM_REGS-1:0]  status_in,
    output logic [NUM_REGS-1:0]     ctrl_wr_pulse
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [31:0]      ctrl_q [NUM_REGS];
    logic             rst_done;
    logic             aw_latched;
    logic             w_latched;
    logic [IDX_W-1:0] aw_idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic [31:0]      wr_idx;
    logic [31:0]      rd_idx;
    logic             wr_hit;
    logic [31:0]      rd_word;
    logic [1:0]       rd_resp;
    logic             unused_addr_bits;

    // rst_done keeps every ready low during reset and for the edge that releases it
    assign s_axi_awready = rst_done & ~aw_latched & ~s_axi_bvalid;
    assign s_axi_wready  = rst_done & ~w_latched & ~s_axi_bvalid;
    assign s_axi_arready = rst_done & ~s_axi_rvalid;

    assign wr_idx = 32'(aw_idx_q);
    assign rd_idx = 32'(s_axi_araddr[ADDR_WIDTH-1:2]);
    assign wr_hit = wr_idx < 32'(NUM_REGS);
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
        assign ctrl_out[32*g +: 32] = ctrl_q[g];
    end

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == 32'(i)) begin
                rd_word = ctrl_q[i];
                rd_resp = RESP_OKAY;
            end
            if (rd_idx == 32'(i + NUM_REGS)) begin
                rd_word = status_in[32*i +: 32];
                rd_resp = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rst_done      <= 1'b0;
            aw_latched    <= 1'b0;
            w_latched     <= 1'b0;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            ctrl_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) ctrl_q[i] <= '0;
        end else begin
            rst_done      <= 1'b1;
            ctrl_wr_pulse <= '0;
            if (s_axi_awready && s_axi_awvalid) begin
                aw_latched <= 1'b1;
                aw_idx_q   <= s_axi_awaddr[ADDR_WIDTH-1:2];
            end
            if (s_axi_wready && s_axi_wvalid) begin
                w_latched <= 1'b1;
                wdata_q   <= s_axi_wdata;
                wstrb_q   <= s_axi_wstrb;
            end
            if (aw_latched && w_latched) begin
                aw_latched   <= 1'b0;
                w_latched    <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_idx == 32'(i)) begin
                        ctrl_wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_q[b]) ctrl_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                    end
                end
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    // Read side never looks at write state, so a same-cycle write shows the old value
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else if (s_axi_arready && s_axi_arvalid) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_word;
            s_axi_rresp  <= rd_resp;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ok_axi4lite_reg_slave.sv
// Directed plus randomized bench for ok_axi4lite_reg_slave against an
// array-based register map model.
module tb_ok_axi4lite_reg_slave;
    localparam int NREGS = 8;

    logic                 clk;
    logic                 rst_n;
    logic [11:0]          awaddr;
    logic                 awvalid;
    logic                 awready;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [11:0]          araddr;
    logic                 arvalid;
    logic                 arready;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;
    logic [32*NREGS-1:0]  ctrl_out;
    logic [32*NREGS-1:0]  status_flat;
    logic [NREGS-1:0]     ctrl_wr_pulse;

    logic [31:0] ctrl_m [NREGS];
    int checks;
    int failures;

    ok_axi4lite_reg_slave #(.ADDR_WIDTH(12), .NUM_REGS(NREGS)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .ctrl_out(ctrl_out), .status_in(status_flat), .ctrl_wr_pulse(ctrl_wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREGS; i++) check(tag, ctrl_out[32*i +: 32], ctrl_m[i]);
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int bhold);
        int idx;
        logic [1:0] exp_resp;
        logic [7:0] exp_pulse;
        logic got;
        idx = int'(addr[11:2]);
        exp_resp = 2'b10;
        exp_pulse = '0;
        if (idx < NREGS) begin
            exp_resp = 2'b00;
            exp_pulse[idx] = 1'b1;
            for (int k = 0; k < 4; k++)
                if (strb[k]) ctrl_m[idx][8*k +: 8] = data[8*k +: 8];
        end
        fork
            begin
                logic rdy;
                repeat (aw_dly) tick();
                awaddr = addr;
                awvalid = 1'b1;
                for (int t = 0; t <= 20; t++) begin
                    if (t == 20) begin timeout_fail("aw_handshake"); break; end
                    rdy = awready;
                    tick();
                    if (rdy) break;
                end
                awvalid = 1'b0;
            end
            begin
                logic rdy;
                repeat (w_dly) tick();
                wdata = data;
                wstrb = strb;
                wvalid = 1'b1;
                for (int t = 0; t <= 20; t++) begin
                    if (t == 20) begin timeout_fail("w_handshake"); break; end
                    rdy = wready;
                    tick();
                    if (rdy) break;
                end
                wvalid = 1'b0;
            end
        join
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (bvalid) begin got = 1'b1; break; end
            tick();
        end
        if (!got) timeout_fail("bvalid_wait");
        check("wr_pulse", 32'(ctrl_wr_pulse), 32'(exp_pulse));
        check("bresp", 32'(bresp), 32'(exp_resp));
        check_regs("ctrl_after_write");
        for (int h = 0; h < bhold; h++) begin
            tick();
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("bresp_hold", 32'(bresp), 32'(exp_resp));
            check("awready_hold", 32'(awready), 32'd0);
            check("wready_hold", 32'(wready), 32'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_clear", 32'(bvalid), 32'd0);
        check("awready_after_b", 32'(awready), 32'd1);
        check("wr_pulse_clear", 32'(ctrl_wr_pulse), 32'd0);
    endtask

    task automatic do_read(input logic [11:0] addr, input int rhold);
        int idx;
        logic [31:0] exp_data;
        logic [1:0] exp_resp;
        logic rdy;
        logic got;
        idx = int'(addr[11:2]);
        exp_data = 32'h0;
        exp_resp = 2'b10;
        if (idx < NREGS) begin
            exp_data = ctrl_m[idx];
            exp_resp = 2'b00;
        end else if (idx < 2 * NREGS) begin
            exp_data = status_flat[32*(idx-NREGS) +: 32];
            exp_resp = 2'b00;
        end
        araddr = addr;
        arvalid = 1'b1;
        for (int t = 0; t <= 20; t++) begin
            if (t == 20) begin timeout_fail("ar_handshake"); break; end
            rdy = arready;
            tick();
            if (rdy) break;
        end
        arvalid = 1'b0;
        status_flat = {NREGS{$urandom}};
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (rvalid) begin got = 1'b1; break; end
            tick();
        end
        if (!got) timeout_fail("rvalid_wait");
        check("rdata", rdata, exp_data);
        check("rresp", 32'(rresp), 32'(exp_resp));
        for (int h = 0; h < rhold; h++) begin
            tick();
            check("rvalid_hold", 32'(rvalid), 32'd1);
            check("rdata_hold", rdata, exp_data);
            check("arready_hold", 32'(arready), 32'd0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rvalid_clear", 32'(rvalid), 32'd0);
        check("arready_after_r", 32'(arready), 32'd1);
    endtask

    initial begin
        logic [31:0] oldv;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        status_flat = '0;
        for (int i = 0; i < NREGS; i++) ctrl_m[i] = '0;

        #2;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        repeat (3) tick();
        check("rst_wready", 32'(wready), 32'd0);
        check_regs("rst_ctrl");
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_awready", 32'(awready), 32'd1);
        check("post_rst_wready", 32'(wready), 32'd1);
        check("post_rst_arready", 32'(arready), 32'd1);

        // Same-cycle AW/W to register 1
        do_write(12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        check("dir_reg1", ctrl_out[63:32], 32'hDEADBEEF);

        // W leads AW by three cycles with a partial strobe
        do_write(12'h000, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        do_write(12'h000, 32'h11223344, 4'b0101, 3, 0, 0);
        check("dir_reg0_strb", ctrl_out[31:0], 32'hFF22FF44);

        // Held-off B response
        do_write(12'h008, 32'h0BADF00D, 4'hF, 0, 2, 5);

        // Status and unmapped reads
        status_flat[31:0] = 32'hCAFEF00D;
        do_read(12'h020, 0);
        status_flat[31:0] = 32'hCAFEF00D;
        araddr = 12'h020;
        do_read(12'h022, 2);
        do_read(12'h040, 1);

        // Write to a read-only word
        do_write(12'h024, 32'h12345678, 4'hF, 1, 0, 1);
        check_regs("ro_write_ctrl");

        // Zero-strobe write still pulses and responds OKAY
        do_write(12'h00C, 32'hFFFFFFFF, 4'h0, 0, 1, 0);

        // AR handshake on the execute edge of a write to the same register
        oldv = ctrl_m[5];
        awaddr = 12'h014; wdata = 32'hA5A5_5A5A; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 12'h014; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        ctrl_m[5] = 32'hA5A5_5A5A;
        check("coll_rvalid", 32'(rvalid), 32'd1);
        check("coll_rdata_old", rdata, oldv);
        check("coll_bvalid", 32'(bvalid), 32'd1);
        check("coll_reg5_new", ctrl_out[191:160], 32'hA5A5_5A5A);
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        check("coll_rvalid_clear", 32'(rvalid), 32'd0);
        check("coll_bvalid_clear", 32'(bvalid), 32'd0);

        // Randomized mixed traffic
        for (int n = 0; n < 60; n++) begin
            int idx;
            logic [11:0] a;
            logic [3:0] s;
            idx = $urandom_range(0, 19);
            a = 12'((idx << 2) | $urandom_range(0, 3));
            s = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3));
        end

        // Reset with both responses pending
        awaddr = 12'h008; wdata = 32'h55AA55AA; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 12'h008; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        check("pre_rst_bvalid", 32'(bvalid), 32'd1);
        check("pre_rst_rvalid", 32'(rvalid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NREGS; i++) ctrl_m[i] = '0;
        check("arst_bvalid", 32'(bvalid), 32'd0);
        check("arst_rvalid", 32'(rvalid), 32'd0);
        check("arst_rdata", rdata, 32'd0);
        check("arst_awready", 32'(awready), 32'd0);
        check("arst_pulse", 32'(ctrl_wr_pulse), 32'd0);
        check_regs("arst_ctrl");
        tick();
        #3 rst_n = 1'b1;
        tick();
        check("rerst_bvalid", 32'(bvalid), 32'd0);
        check("rerst_awready", 32'(awready), 32'd1);
        do_write(12'h01C, 32'h600DCAFE, 4'hF, 0, 0, 0);
        do_read(12'h01C, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ok_axi4lite_reg_slave.md
OK_AXI4LITE_REG_SLAVE -- requirements
Module: ok_axi4lite_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning byte-address width of AW/AR channels.
REQ-002 SHALL have parameter NUM_REGS, default 8, meaning count of read/write control registers (1..64); data width is fixed at 32.
REQ-003 SHALL have port s_axi_aclk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port s_axi_aresetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports s_axi_awaddr  in  ADDR_WIDTH, s_axi_awvalid  in  1, s_axi_awready  out  1  write-address channel.
REQ-006 SHALL have ports s_axi_wdata  in  32, s_axi_wstrb  in  4, s_axi_wvalid  in  1, s_axi_wready  out  1  write-data channel.
REQ-007 SHALL have ports s_axi_bresp  out  2, s_axi_bvalid  out  1, s_axi_bready  in  1  write-response channel.
REQ-008 SHALL have ports s_axi_araddr  in  ADDR_WIDTH, s_axi_arvalid  in  1, s_axi_arready  out  1  read-address channel.
REQ-009 SHALL have ports s_axi_rdata  out  32, s_axi_rresp  out  2, s_axi_rvalid  out  1, s_axi_rready  in  1  read-data channel.
REQ-010 SHALL have port ctrl_out  output  32*NUM_REGS  flat control registers; register i at bits [32i+31:32i].
REQ-011 SHALL have port status_in  input  32*NUM_REGS  flat read-only status words, same packing.
REQ-012 SHALL have port ctrl_wr_pulse  output  NUM_REGS  one-cycle strobe, bit i set the cycle after register i is written.

Function
REQ-013 SHALL decode word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
REQ-014 SHALL map index 0..NUM_REGS-1 to RW control regs, NUM_REGS..2*NUM_REGS-1 to RO status_in words, all other indices unmapped.
REQ-015 SHALL assert s_axi_awready when no write address is latched and s_axi_bvalid is low; AW handshake latches awaddr.
REQ-016 SHALL assert s_axi_wready when no write data is latched and s_axi_bvalid is low; W handshake latches wdata and wstrb.
REQ-017 SHALL accept AW and W in either order or the same cycle; write executes the first cycle both are latched.
REQ-018 SHALL on write execute update only bytes with wstrb[k]=1 of a RW register, clear both latches, set bvalid with bresp=OKAY (2'b00) next cycle.
REQ-019 SHALL on write to RO or unmapped index leave all registers unchanged, assert no ctrl_wr_pulse, and respond bresp=SLVERR (2'b10).
REQ-020 SHALL hold s_axi_bvalid and s_axi_bresp stable until s_axi_bready; bvalid clears the cycle after the B handshake.
REQ-021 SHALL assert s_axi_arready when s_axi_rvalid is low; AR handshake samples the addressed word and sets rvalid next cycle.
REQ-022 SHALL return rresp=OKAY for mapped indices, rresp=SLVERR with rdata=32'h0 for unmapped.
REQ-023 SHALL hold s_axi_rdata/s_axi_rresp/s_axi_rvalid stable until s_axi_rready; rvalid clears the cycle after the R handshake.
REQ-024 SHALL keep read and write paths independent; an AR handshake in the same cycle as a write execute to the same register returns the pre-write value.
REQ-025 SHALL ignore wstrb=4'h0 writes for data but still respond OKAY and pulse ctrl_wr_pulse for RW targets.
REQ-026 SHALL sample status_in combinationally at the AR handshake cycle into the rdata register.

Reset
REQ-027 SHALL, while s_axi_aresetn=0, drive all ready/valid outputs 0, bresp/rresp 2'b00, rdata 0, ctrl_out all 0, ctrl_wr_pulse 0, and clear AW/W latches.
REQ-028 SHALL raise awready/wready/arready on the first clock edge after reset deassertion.
REQ-029 SHALL abandon any in-flight transaction on reset assertion with no response issued afterward.

Verification
REQ-030 AW addr 0x004 and W 0xDEADBEEF strb 4'hF same cycle, bready=1 -> ctrl_out reg1=0xDEADBEEF, ctrl_wr_pulse=8'h02 one cycle, bresp=00.
REQ-031 W 0x11223344 strb 4'b0101 three cycles before AW 0x000 (reg0=0xFFFFFFFF) -> reg0=0xFF22FF44, awready low is never required to accept W first.
REQ-032 bready held low 5 cycles -> bvalid/bresp stable, awready and wready low throughout; new AW accepted the cycle after bvalid drops.
REQ-033 Read 0x020 with status_in word0=0xCAFEF00D (NUM_REGS=8) -> rdata=0xCAFEF00D, rresp=00; read 0x040 -> rdata=0, rresp=10.
REQ-034 Write 0x024 (RO) -> bresp=10, ctrl_out unchanged, ctrl_wr_pulse=0.
REQ-035 Assert reset while bvalid and rvalid high -> both drop immediately, ctrl_out=0; post-reset write/read completes normally.
